// File: rtl/regfile_mp_pkg.sv
// Shared defaults, read-source encoding and zero-register helper for the
// multi-port register file and its read ports.
package regfile_mp_pkg;

    localparam int WIDTH_DEFAULT    = 64;
    localparam int DEPTH_DEFAULT    = 32;
    localparam int AW_DEFAULT       = 5;
    localparam int NUM_RD_DEFAULT   = 2;
    localparam int ZERO_REG_DEFAULT = 31;
    localparam int BYPASS_DEFAULT   = 1;

    // Setting ZERO_REG to DEPTH means "no zero register"; no real index reaches it.
    localparam int RF_NO_ZERO = DEPTH_DEFAULT;

    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_BYP1  = 2'd1,
        SRC_BYP0  = 2'd2,
        SRC_ARRAY = 2'd3
    } rdSrc_e;

    function automatic logic isZeroReg(input int unsigned addr, input int unsigned zeroReg);
        return addr == zeroReg;
    endfunction

endpackage

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: zero-register override, same-cycle write
// forwarding and the storage/busy lookup.
module regfile_mp_read_port
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int BYPASS   = BYPASS_DEFAULT
) (
    input  logic             reset,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    input  logic             wrEn0,
    input  logic [AW-1:0]    wrAddr0,
    input  logic [WIDTH-1:0] wrData0,
    input  logic             wrEn1,
    input  logic [AW-1:0]    wrAddr1,
    input  logic [WIDTH-1:0] wrData1,
    output logic [WIDTH-1:0] data,
    output logic             busyOut
);

    rdSrc_e src;
    logic   hit0;
    logic   hit1;

    // wrEnN already excludes reset and the zero register, so a hit is always
    // a write that will actually land.
    always_comb begin
        hit0 = (BYPASS != 0) && wrEn0 && (wrAddr0 == addr);
        hit1 = (BYPASS != 0) && wrEn1 && (wrAddr1 == addr);
    end

    always_comb begin
        src = SRC_ARRAY;
        if (reset || isZeroReg(32'(addr), ZERO_REG)) begin
            src = SRC_ZERO;
        end else if (hit1) begin
            src = SRC_BYP1;
        end else if (hit0) begin
            src = SRC_BYP0;
        end
    end

    // Forwarded data is by definition not awaiting a result, so busy reads 0.
    always_comb begin
        data    = '0;
        busyOut = 1'b0;
        unique case (src)
            SRC_ZERO: begin
                data    = '0;
                busyOut = 1'b0;
            end
            SRC_BYP1: data = wrData1;
            SRC_BYP0: data = wrData0;
            SRC_ARRAY: begin
                data    = regs[addr];
                busyOut = busy[addr];
            end
            default: begin
                data    = '0;
                busyOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports (port 1 wins collisions),
// NUM_RD read ports, optional zero register and a per-register busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int NUM_RD   = NUM_RD_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int BYPASS   = BYPASS_DEFAULT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_RD*AW-1:0]    RA,
    output logic [NUM_RD*WIDTH-1:0] BusR,
    output logic [NUM_RD-1:0]       BusyR,
    input  logic                    RegWr0,
    input  logic [AW-1:0]           RW0,
    input  logic [WIDTH-1:0]        BusW0,
    input  logic                    RegWr1,
    input  logic [AW-1:0]           RW1,
    input  logic [WIDTH-1:0]        BusW1,
    input  logic                    RsvWr,
    input  logic [AW-1:0]           RsvAddr
);

    generate
        if (AW != $clog2(DEPTH)) begin : gAwCheck
            $error("regfile_mp: AW (%0d) must equal $clog2(DEPTH) (%0d)", AW, $clog2(DEPTH));
        end
        if (NUM_RD < 1 || NUM_RD > 4) begin : gNumRdCheck
            $error("regfile_mp: NUM_RD (%0d) must be in 1..4", NUM_RD);
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
            $error("regfile_mp: DEPTH (%0d) must be a power of two >= 2", DEPTH);
        end
    endgenerate

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             wrEn0;
    logic             wrEn1;
    logic             wrEn0Kept;
    logic             rsvEn;

    // Accepted-request qualifiers; anything presented during reset is discarded.
    always_comb begin
        wrEn0     = RegWr0 && !Reset && !isZeroReg(32'(RW0), ZERO_REG);
        wrEn1     = RegWr1 && !Reset && !isZeroReg(32'(RW1), ZERO_REG);
        wrEn0Kept = wrEn0 && !(wrEn1 && (RW1 == RW0));
        rsvEn     = RsvWr && !Reset && !isZeroReg(32'(RsvAddr), ZERO_REG);
    end

    // Clears are applied before the set so a same-cycle reservation wins.
    always_comb begin
        busyNext = busy;
        if (wrEn0) begin
            busyNext[RW0] = 1'b0;
        end
        if (wrEn1) begin
            busyNext[RW1] = 1'b0;
        end
        if (rsvEn) begin
            busyNext[RsvAddr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wrEn0Kept) begin
                regs[RW0] <= BusW0;
            end
            if (wrEn1) begin
                regs[RW1] <= BusW1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : gRead
            regfile_mp_read_port #(
                .WIDTH    (WIDTH),
                .DEPTH    (DEPTH),
                .AW       (AW),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) uReadPort (
                .reset    (Reset),
                .addr     (RA[k*AW +: AW]),
                .regs     (regs),
                .busy     (busy),
                .wrEn0    (wrEn0),
                .wrAddr0  (RW0),
                .wrData0  (BusW0),
                .wrEn1    (wrEn1),
                .wrAddr1  (RW1),
                .wrData1  (BusW1),
                .data     (BusR[k*WIDTH +: WIDTH]),
                .busyOut  (BusyR[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build with and without
// bypass, plus a 4-port / 16-entry / 32-bit build with no zero register.
module tb_regfile_mp;

    logic         Clk;
    logic         Reset;

    logic [9:0]   ra;
    logic [127:0] busR;
    logic [1:0]   busyR;
    logic [127:0] busRNb;
    logic [1:0]   busyRNb;
    logic         regWr0;
    logic [4:0]   rw0;
    logic [63:0]  busW0;
    logic         regWr1;
    logic [4:0]   rw1;
    logic [63:0]  busW1;
    logic         rsvWr;
    logic [4:0]   rsvAddr;

    logic [15:0]  raP;
    logic [127:0] busRP;
    logic [3:0]   busyRP;
    logic         regWr0P;
    logic [3:0]   rw0P;
    logic [31:0]  busW0P;
    logic         regWr1P;
    logic [3:0]   rw1P;
    logic [31:0]  busW1P;
    logic         rsvWrP;
    logic [3:0]   rsvAddrP;

    logic [31:0]  modelP [16];

    int assertCount = 0;
    int failCount   = 0;

    regfile_mp dut (
        .Clk(Clk), .Reset(Reset), .RA(ra), .BusR(busR), .BusyR(busyR),
        .RegWr0(regWr0), .RW0(rw0), .BusW0(busW0),
        .RegWr1(regWr1), .RW1(rw1), .BusW1(busW1),
        .RsvWr(rsvWr), .RsvAddr(rsvAddr)
    );

    regfile_mp #(.BYPASS(0)) dutNb (
        .Clk(Clk), .Reset(Reset), .RA(ra), .BusR(busRNb), .BusyR(busyRNb),
        .RegWr0(regWr0), .RW0(rw0), .BusW0(busW0),
        .RegWr1(regWr1), .RW1(rw1), .BusW1(busW1),
        .RsvWr(rsvWr), .RsvAddr(rsvAddr)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(16), .AW(4), .NUM_RD(4), .ZERO_REG(16), .BYPASS(1)) dutP (
        .Clk(Clk), .Reset(Reset), .RA(raP), .BusR(busRP), .BusyR(busyRP),
        .RegWr0(regWr0P), .RW0(rw0P), .BusW0(busW0P),
        .RegWr1(regWr1P), .RW1(rw1P), .BusW1(busW1P),
        .RsvWr(rsvWrP), .RsvAddr(rsvAddrP)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                                 input logic rs, input logic [4:0] ras);
        regWr0 = w0; rw0 = a0; busW0 = d0;
        regWr1 = w1; rw1 = a1; busW1 = d1;
        rsvWr = rs; rsvAddr = ras;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        ra = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        regWr0P = 0; rw0P = 0; busW0P = 0; regWr1P = 0; rw1P = 0; busW1P = 0;
        rsvWrP = 0; rsvAddrP = 0; raP = '0;
        for (int i = 0; i < 16; i++) modelP[i] = '0;

        // Writes presented while reset is high must be discarded.
        ra = {5'd0, 5'd3};
        applyStimulus(1, 3, 64'hDEAD, 0, 0, 0, 1, 3);
        #2;
        checkOutput("resetBusR", busR[63:0], 64'h0);
        checkOutput("resetBusyR", {62'd0, busyR}, 64'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        #1;
        checkOutput("resetWriteDiscarded", busR[63:0], 64'h0);
        checkOutput("resetRsvDiscarded", {63'd0, busyR[0]}, 64'h0);

        // Reset mid-run.
        applyStimulus(1, 3, 64'hDEAD, 0, 0, 0, 0, 0);
        #1;
        checkOutput("bypassR3", busR[63:0], 64'hDEAD);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("storedR3", busR[63:0], 64'hDEAD);
        Reset = 1'b1;
        #1;
        checkOutput("midResetR3", busR[63:0], 64'h0);
        nextCycle();
        Reset = 1'b0;
        #1;
        checkOutput("afterResetR3", busR[63:0], 64'h0);

        // Zero register.
        ra = {5'd31, 5'd31};
        applyStimulus(1, 31, 64'h1234, 1, 31, 64'h5678, 1, 31);
        #1;
        checkOutput("zeroRegBypass", busR[63:0], 64'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("zeroRegData", busR[127:64], 64'h0);
        checkOutput("zeroRegBusy", {62'd0, busyR}, 64'h0);

        // Write collision: port 1 wins.
        ra = {5'd5, 5'd0};
        applyStimulus(1, 5, 64'hA, 1, 5, 64'hB, 0, 0);
        #1;
        checkOutput("collisionBypass", busR[127:64], 64'hB);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("collisionStored", busR[127:64], 64'hB);

        // Bypass vs. no bypass on r7.
        ra = {5'd0, 5'd7};
        applyStimulus(1, 7, 64'h11, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 7, 64'h77, 0, 0);
        #1;
        checkOutput("bypassOn", busR[63:0], 64'h77);
        checkOutput("bypassOffOld", busRNb[63:0], 64'h11);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("bypassOffNew", busRNb[63:0], 64'h77);

        // Scoreboard on r9.
        ra = {5'd9, 5'd0};
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        #1;
        checkOutput("rsvSameCycle", {63'd0, busyR[1]}, 64'h0);
        nextCycle();
        applyStimulus(1, 9, 64'h99, 0, 0, 0, 1, 9);
        #1;
        checkOutput("rsvSet", {63'd0, busyRNb[1]}, 64'h1);
        checkOutput("rsvBypassBusy", {63'd0, busyR[1]}, 64'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 9, 64'h42, 0, 0);
        #1;
        checkOutput("rsvWinsBusy", {63'd0, busyRNb[1]}, 64'h1);
        checkOutput("rsvWinsData", busRNb[127:64], 64'h99);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        ra = {5'd9, 5'd9};
        #1;
        checkOutput("writeClearsBusy", {62'd0, busyR}, 64'h0);
        checkOutput("port0R9", busR[63:0], 64'h42);
        checkOutput("port1R9", busR[127:64], 64'h42);

        // Small build: 16 entries, no zero register, 4 read ports.
        regWr0P = 1; rw0P = 4'd15; busW0P = 32'hCAFEF00D;
        modelP[15] = 32'hCAFEF00D;
        nextCycle();
        regWr0P = 0;
        raP = {4'd15, 4'd0, 4'd0, 4'd0};
        #1;
        checkOutput("paramR15", {32'd0, busRP[127:96]}, 64'hCAFEF00D);
        for (int n = 0; n < 24; n++) begin
            regWr0P = 1'($urandom_range(0, 1));
            rw0P    = 4'($urandom_range(0, 15));
            busW0P  = $urandom;
            regWr1P = 1'($urandom_range(0, 1));
            rw1P    = 4'($urandom_range(0, 15));
            busW1P  = $urandom;
            if (regWr0P && !(regWr1P && rw1P == rw0P)) modelP[rw0P] = busW0P;
            if (regWr1P) modelP[rw1P] = busW1P;
            nextCycle();
        end
        regWr0P = 0;
        regWr1P = 0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) raP[k*4 +: 4] = 4'(g*4 + (3 - k));
            #1;
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("paramRead_g%0d_p%0d", g, k),
                            {32'd0, busRP[k*32 +: 32]}, {32'd0, modelP[g*4 + (3 - k)]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
